// File: rtl/tagged_cache_fifo_pkg.sv
// Shared types and width helpers for the tagged cache FIFO.
//   idx_w()      : index width for an N-entry structure (at least 1 bit)
//   lk_flags_t   : registered lookup response flags (hit / found)
package tagged_cache_fifo_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic hit;    // served from the lookaside cache
        logic found;  // present in the cache or the live FIFO
    } lk_flags_t;

endpackage

// File: rtl/lru_age_tracker.sv
// Replacement state for the lookaside cache.
//   clk, rst_n   : clock, async active-low reset
//   valid        : per-entry valid bits (invalid entries are filled first)
//   touch        : an entry was hit or filled this cycle
//   touch_idx    : that entry
//   fill         : a fill is happening this cycle (advances round-robin)
//   victim_idx   : entry to be replaced by the next fill
// Ages form a permutation of 0..ENTRIES-1; age 0 is most recently used.
module lru_age_tracker
#(
    parameter int ENTRIES = 4,
    parameter int POLICY  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ENTRIES-1:0]         valid,
    input  logic                       touch,
    input  logic [$clog2(ENTRIES)-1:0] touch_idx,
    input  logic                       fill,
    output logic [$clog2(ENTRIES)-1:0] victim_idx
);
    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0][IW-1:0] age;
    logic [IW-1:0]              rr_ptr;
    logic [IW-1:0]              free_idx;
    logic [IW-1:0]              lru_idx;
    logic [IW-1:0]              touch_age;
    logic                       all_valid;

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) free_idx = IW'(i);
        lru_idx = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (age[i] == IW'(ENTRIES - 1)) lru_idx = IW'(i);
    end

    assign all_valid  = &valid;
    assign touch_age  = age[touch_idx];
    assign victim_idx = !all_valid    ? free_idx :
                        (POLICY == 1) ? lru_idx  : rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) age[i] <= IW'(i);
            rr_ptr <= '0;
        end else begin
            if (touch) begin
                // Accessed entry becomes youngest; everything younger than
                // its old age ages by one, so the permutation is preserved.
                for (int i = 0; i < ENTRIES; i++) begin
                    if (IW'(i) == touch_idx)    age[i] <= '0;
                    else if (age[i] < touch_age) age[i] <= age[i] + IW'(1);
                end
            end
            // Pointer only moves when it actually supplied the victim.
            if (POLICY == 0 && fill && all_valid) rr_ptr <= rr_ptr + IW'(1);
        end
    end

endmodule

// File: rtl/tagged_cache_fifo.sv
// Tagged FIFO with keyed lookup and a small fully-associative lookaside cache.
//   wr_valid/wr_ready/wr_data/wr_tag : push port (dropped while full)
//   pop_en -> pop_valid/pop_data/pop_tag : strict FIFO pop, 1-cycle latency
//   lk_valid/lk_tag -> rsp_valid/rsp_data/rsp_hit/rsp_found : lookup, 1-cycle
//   full/empty/count : occupancy from registered pointers
//   clear_stats, hit_count, miss_count : saturating cache statistics
module tagged_cache_fifo
    import tagged_cache_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int DEPTH_LOG2    = 4,
    parameter int CACHE_ENTRIES = 4,
    parameter int REPL_POLICY   = 1,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic                  pop_en,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [TAG_WIDTH-1:0]  pop_tag,
    input  logic                  lk_valid,
    input  logic [TAG_WIDTH-1:0]  lk_tag,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_found,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  clear_stats,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int IW    = idx_w(CACHE_ENTRIES);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // FIFO storage and wrap-bit pointers
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag  [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx, slot;
    logic                  do_push, do_pop;

    // Lookaside cache
    logic [CACHE_ENTRIES-1:0] c_valid;
    logic [TAG_WIDTH-1:0]     c_tag  [CACHE_ENTRIES];
    logic [DATA_WIDTH-1:0]    c_data [CACHE_ENTRIES];
    logic                     c_hit, f_found, fill, touch;
    logic [IW-1:0]            c_hit_idx, victim_idx, touch_idx;
    logic [DATA_WIDTH-1:0]    c_hit_data, f_data;
    lk_flags_t                rsp_flags;

    assign wr_idx   = wr_ptr[DEPTH_LOG2-1:0];
    assign rd_idx   = rd_ptr[DEPTH_LOG2-1:0];
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign do_push  = wr_valid && !full;
    assign do_pop   = pop_en && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_idx] <= wr_data;
            mem_tag[wr_idx]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            pop_tag   <= '0;
        end else begin
            pop_valid <= do_pop;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                pop_data <= mem_data[rd_idx];
                pop_tag  <= mem_tag[rd_idx];
            end
        end
    end

    // Associative search on start-of-cycle state. The FIFO scan walks from
    // oldest to newest so the last match (newest) wins.
    always_comb begin
        c_hit      = 1'b0;
        c_hit_idx  = '0;
        c_hit_data = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (c_valid[i] && c_tag[i] == lk_tag) begin
                c_hit      = 1'b1;
                c_hit_idx  = IW'(i);
                c_hit_data = c_data[i];
            end
        end
        f_found = 1'b0;
        f_data  = '0;
        slot    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_idx + DEPTH_LOG2'(k);
            if (PW'(k) < count && mem_tag[slot] == lk_tag) begin
                f_found = 1'b1;
                f_data  = mem_data[slot];
            end
        end
    end

    assign fill      = lk_valid && !c_hit && f_found;
    assign touch     = lk_valid && (c_hit || f_found);
    assign touch_idx = c_hit ? c_hit_idx : victim_idx;

    lru_age_tracker #(
        .ENTRIES (CACHE_ENTRIES),
        .POLICY  (REPL_POLICY)
    ) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (c_valid),
        .touch      (touch),
        .touch_idx  (touch_idx),
        .fill       (fill),
        .victim_idx (victim_idx)
    );

    always_ff @(posedge clk) begin
        if (fill) begin
            c_tag[victim_idx]  <= lk_tag;
            c_data[victim_idx] <= f_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid    <= '0;
            rsp_valid  <= 1'b0;
            rsp_flags  <= '0;
            rsp_data   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (fill) c_valid[victim_idx] <= 1'b1;
            rsp_valid       <= lk_valid;
            rsp_flags.hit   <= lk_valid && c_hit;
            rsp_flags.found <= lk_valid && (c_hit || f_found);
            rsp_data        <= !lk_valid ? '0 : (c_hit ? c_hit_data : f_data);
            if (clear_stats)
                hit_count <= '0;
            else if (lk_valid && c_hit && hit_count != STAT_MAX)
                hit_count <= hit_count + STAT_WIDTH'(1);
            if (clear_stats)
                miss_count <= '0;
            else if (lk_valid && !c_hit && miss_count != STAT_MAX)
                miss_count <= miss_count + STAT_WIDTH'(1);
        end
    end

    assign rsp_hit   = rsp_flags.hit;
    assign rsp_found = rsp_flags.found;

endmodule

// File: tb/tb_tagged_cache_fifo.sv
// Bench: an LRU instance checked every cycle against a queue/recency-list
// model plus literal expectations, and a small round-robin instance with
// 3-bit stats checked by literals only.
module tb_tagged_cache_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LRU instance (defaults)
    logic        wr_valid = 0, pop_en = 0, lk_valid = 0, clear_stats = 0;
    logic [31:0] wr_data = 0;
    logic [7:0]  wr_tag = 0, lk_tag = 0;
    logic        wr_ready, pop_valid, rsp_valid, rsp_hit, rsp_found, full, empty;
    logic [31:0] pop_data, rsp_data, hit_count, miss_count;
    logic [7:0]  pop_tag;
    logic [4:0]  count;

    tagged_cache_fifo u_lru (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_tag(wr_tag), .pop_en(pop_en), .pop_valid(pop_valid),
        .pop_data(pop_data), .pop_tag(pop_tag), .lk_valid(lk_valid), .lk_tag(lk_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .rsp_found(rsp_found), .full(full), .empty(empty), .count(count),
        .clear_stats(clear_stats), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Round-robin instance: depth 4, 3-bit stats
    logic        b_wr_valid = 0, b_pop_en = 0, b_lk_valid = 0, b_clear_stats = 0;
    logic [31:0] b_wr_data = 0;
    logic [7:0]  b_wr_tag = 0, b_lk_tag = 0;
    logic        b_wr_ready, b_pop_valid, b_rsp_valid, b_rsp_hit, b_rsp_found, b_full, b_empty;
    logic [31:0] b_pop_data, b_rsp_data;
    logic [7:0]  b_pop_tag;
    logic [2:0]  b_count, b_hit_count, b_miss_count;

    tagged_cache_fifo #(
        .DATA_WIDTH(32), .TAG_WIDTH(8), .DEPTH_LOG2(2), .CACHE_ENTRIES(4),
        .REPL_POLICY(0), .STAT_WIDTH(3)
    ) u_rr (
        .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_data(b_wr_data), .wr_tag(b_wr_tag), .pop_en(b_pop_en), .pop_valid(b_pop_valid),
        .pop_data(b_pop_data), .pop_tag(b_pop_tag), .lk_valid(b_lk_valid), .lk_tag(b_lk_tag),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_hit(b_rsp_hit),
        .rsp_found(b_rsp_found), .full(b_full), .empty(b_empty), .count(b_count),
        .clear_stats(b_clear_stats), .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model of the LRU instance ----------------
    typedef struct { logic [7:0] tag; logic [31:0] data; } ent_t;
    ent_t        m_q[$];          // live FIFO contents, oldest first
    logic        mcv[4];
    logic [7:0]  mct[4];
    logic [31:0] mcd[4];
    int          rec[$];          // cache entries, most recently used first
    logic [31:0] m_hit, m_miss;
    logic        e_pop_valid, e_rsp_valid, e_rsp_hit, e_rsp_found;
    logic [31:0] e_pop_data, e_rsp_data;
    logic [7:0]  e_pop_tag;
    int          mh, mf, mv;
    bit          was_full;

    task automatic touch(input int e);
        for (int k = 0; k < rec.size(); k++)
            if (rec[k] == e) begin rec.delete(k); break; end
        rec.push_front(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            rec.delete();
            for (int i = 0; i < 4; i++) begin mcv[i] = 0; rec.push_back(i); end
            m_hit = 0; m_miss = 0;
            e_pop_valid = 0; e_pop_data = 0; e_pop_tag = 0;
            e_rsp_valid = 0; e_rsp_hit = 0; e_rsp_found = 0; e_rsp_data = 0;
        end else begin
            was_full    = (m_q.size() == 16);
            e_rsp_valid = lk_valid;
            e_rsp_hit   = 0; e_rsp_found = 0; e_rsp_data = 0;
            if (lk_valid) begin
                mh = -1;
                for (int i = 0; i < 4; i++) if (mcv[i] && mct[i] == lk_tag) mh = i;
                if (mh >= 0) begin
                    e_rsp_hit = 1; e_rsp_found = 1; e_rsp_data = mcd[mh];
                    if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
                    touch(mh);
                end else begin
                    if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
                    mf = -1;
                    foreach (m_q[k]) if (m_q[k].tag == lk_tag) mf = k;
                    if (mf >= 0) begin
                        e_rsp_found = 1; e_rsp_data = m_q[mf].data;
                        mv = -1;
                        for (int i = 3; i >= 0; i--) if (!mcv[i]) mv = i;
                        if (mv < 0) mv = rec[rec.size() - 1];
                        mcv[mv] = 1; mct[mv] = lk_tag; mcd[mv] = e_rsp_data;
                        touch(mv);
                    end
                end
            end
            if (clear_stats) begin m_hit = 0; m_miss = 0; end
            e_pop_valid = 0;
            if (pop_en && m_q.size() > 0) begin
                e_pop_valid = 1; e_pop_tag = m_q[0].tag; e_pop_data = m_q[0].data;
                void'(m_q.pop_front());
            end
            if (wr_valid && !was_full) m_q.push_back('{tag: wr_tag, data: wr_data});
        end
    end

    always @(negedge clk) begin
        chk("count",      64'(count),      64'(m_q.size()));
        chk("full",       64'(full),       64'(m_q.size() == 16));
        chk("empty",      64'(empty),      64'(m_q.size() == 0));
        chk("wr_ready",   64'(wr_ready),   64'(m_q.size() != 16));
        chk("pop_valid",  64'(pop_valid),  64'(e_pop_valid));
        chk("pop_data",   64'(pop_data),   64'(e_pop_data));
        chk("pop_tag",    64'(pop_tag),    64'(e_pop_tag));
        chk("rsp_valid",  64'(rsp_valid),  64'(e_rsp_valid));
        if (e_rsp_valid) begin
            chk("rsp_hit",   64'(rsp_hit),   64'(e_rsp_hit));
            chk("rsp_found", 64'(rsp_found), 64'(e_rsp_found));
            chk("rsp_data",  64'(rsp_data),  64'(e_rsp_data));
        end
        chk("hit_count",  64'(hit_count),  64'(m_hit));
        chk("miss_count", 64'(miss_count), 64'(m_miss));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(); @(posedge clk); #1; endtask

    task automatic push(input logic [7:0] t, input logic [31:0] d);
        wr_valid = 1; wr_tag = t; wr_data = d; cyc(); wr_valid = 0;
    endtask
    task automatic look(input logic [7:0] t);
        lk_valid = 1; lk_tag = t; cyc(); lk_valid = 0;
    endtask
    task automatic bpush(input logic [7:0] t);
        b_wr_valid = 1; b_wr_tag = t; b_wr_data = 32'h200 + 32'(t); cyc(); b_wr_valid = 0;
    endtask
    task automatic blook(input logic [7:0] t);
        b_lk_valid = 1; b_lk_tag = t; cyc(); b_lk_valid = 0;
    endtask
    task automatic bpop();
        b_pop_en = 1; cyc(); b_pop_en = 0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst.count", count, 0);   chk("rst.empty", empty, 1);
        chk("rst.wr_ready", wr_ready, 1); chk("rst.pop_data", pop_data, 0);
        chk("rst.rsp_valid", rsp_valid, 0); chk("rst.miss", miss_count, 0);
        rst_n = 1;

        // Fill to full; 17th push dropped
        for (int t = 8'h10; t <= 8'h1F; t++) push(8'(t), 32'hA000_0000 | 32'(t));
        chk("p1.full", full, 1); chk("p1.wr_ready", wr_ready, 0); chk("p1.count", count, 16);
        push(8'h77, 32'h7777);
        chk("p1.drop_count", count, 16);

        look(8'h13);
        chk("p2.found", rsp_found, 1); chk("p2.hit", rsp_hit, 0);
        chk("p2.data", rsp_data, 32'hA000_0013); chk("p2.miss", miss_count, 1);
        look(8'h13);
        chk("p2.hit2", rsp_hit, 1); chk("p2.hitcnt", hit_count, 1);

        // Pop + push while full, plus lookup of the entry being popped
        pop_en = 1; wr_valid = 1; wr_tag = 8'h77; lk_valid = 1; lk_tag = 8'h10;
        cyc(); pop_en = 0; wr_valid = 0; lk_valid = 0;
        chk("p6.pop_valid", pop_valid, 1); chk("p6.pop_tag", pop_tag, 8'h10);
        chk("p6.pop_data", pop_data, 32'hA000_0010); chk("p6.count", count, 15);
        chk("p6.lk_popped", rsp_found, 1); chk("p6.lk_data", rsp_data, 32'hA000_0010);
        pop_en = 1; cyc(); pop_en = 0;
        chk("p3.pop_tag", pop_tag, 8'h11);

        push(8'h20, 32'h0000_AAAA);
        push(8'h20, 32'h0000_BBBB);
        chk("p3.count", count, 16);
        look(8'h20);
        chk("p3.newest", rsp_data, 32'h0000_BBBB); chk("p3.miss", miss_count, 3);
        look(8'h99);
        chk("p3.nf_found", rsp_found, 0); chk("p3.nf_data", rsp_data, 0);
        chk("p3.nf_miss", miss_count, 4);
        look(8'h10);
        chk("p3.copy_hit", rsp_hit, 1); chk("p3.copy_data", rsp_data, 32'hA000_0010);
        look(8'h11);
        chk("p3.gone", rsp_found, 0);

        pop_en = 1; cyc(); pop_en = 0;
        pop_en = 1; wr_valid = 1; wr_tag = 8'h21; wr_data = 32'h21; cyc();
        pop_en = 0; wr_valid = 0;
        chk("pp.count", count, 15); chk("pp.pop_tag", pop_tag, 8'h13);

        // Reset while a lookup is in flight
        lk_valid = 1; lk_tag = 8'h14; cyc();
        chk("rst.pre_valid", rsp_valid, 1);
        #2 rst_n = 0; #1;
        chk("rst.rsp_valid", rsp_valid, 0); chk("rst.count2", count, 0);
        chk("rst.full2", full, 0); chk("rst.hitcnt", hit_count, 0);
        cyc(); lk_valid = 0;
        chk("rst.suppress", rsp_valid, 0);
        rst_n = 1; cyc();

        // LRU replacement
        pop_en = 1; cyc(); pop_en = 0;
        chk("e.pop_empty", pop_valid, 0);
        wr_valid = 1; wr_tag = 1; wr_data = 32'h101; lk_valid = 1; lk_tag = 1;
        cyc(); wr_valid = 0; lk_valid = 0;
        chk("e.push_invis", rsp_found, 0); chk("e.count", count, 1);
        for (int t = 2; t <= 5; t++) push(8'(t), 32'h100 + 32'(t));
        for (int t = 1; t <= 4; t++) look(8'(t));
        chk("l.fills_miss", miss_count, 5);
        look(1); chk("l.hit1", rsp_hit, 1);
        look(5); chk("l.fill5", rsp_hit, 0);
        look(1); chk("l.keep1", rsp_hit, 1);
        look(3); chk("l.keep3", rsp_hit, 1);
        look(4); chk("l.keep4", rsp_hit, 1);
        look(2);
        chk("l.evict2", rsp_hit, 0); chk("l.found2", rsp_found, 1);
        chk("l.data2", rsp_data, 32'h102);

        clear_stats = 1; lk_valid = 1; lk_tag = 1; cyc(); clear_stats = 0; lk_valid = 0;
        chk("cs.rsp_hit", rsp_hit, 1); chk("cs.hitcnt", hit_count, 0);
        chk("cs.misscnt", miss_count, 0);

        // Round-robin replacement and stat saturation
        for (int t = 1; t <= 4; t++) bpush(8'(t));
        chk("rr.full", b_full, 1); chk("rr.count", b_count, 4);
        for (int t = 1; t <= 4; t++) blook(8'(t));
        blook(1); chk("rr.hit1", b_rsp_hit, 1);
        bpop(); chk("rr.pop1", b_pop_tag, 1);
        bpush(5);
        blook(5);
        chk("rr.fill5", b_rsp_found, 1); chk("rr.data5", b_rsp_data, 32'h205);
        blook(1); chk("rr.evict1", b_rsp_found, 0);
        bpop(); chk("rr.pop2", b_pop_tag, 2);
        bpush(6);
        blook(6); chk("rr.fill6", b_rsp_found, 1);
        blook(2); chk("rr.evict2", b_rsp_found, 0);
        chk("rr.miss_sat", b_miss_count, 7);
        blook(3); chk("rr.keep3", b_rsp_hit, 1);
        chk("rr.hitcnt", b_hit_count, 2);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
